// File: rtl/reorder_buffer.sv
// In-order retirement buffer indexed by RRF tag: allocates a tag per dispatch,
// records completions from two finish ports and retires the oldest finished entry.
module reorder_buffer #(
  parameter int RRF_SEL = 6,
  parameter int REG_SEL = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               dp_en_i,
  input  logic               dp_dst_en_i,
  input  logic [REG_SEL-1:0] dp_dst_num_i,
  output logic [RRF_SEL-1:0] dp_rrftag_o,
  output logic               dp_stall_o,
  output logic [RRF_SEL:0]   free_num_o,
  input  logic               fin1_en_i,
  input  logic [RRF_SEL-1:0] fin1_rrftag_i,
  input  logic               fin2_en_i,
  input  logic [RRF_SEL-1:0] fin2_rrftag_i,
  output logic               commit_valid_o,
  output logic               completed_we_o,
  output logic [REG_SEL-1:0] completed_dst_num_o,
  output logic [RRF_SEL-1:0] completed_dst_rrftag_o
);

  localparam int RRF_NUM = 2 ** RRF_SEL;
  localparam logic [RRF_SEL:0]   FULL_COUNT = {1'b1, {RRF_SEL{1'b0}}};
  localparam logic [RRF_SEL:0]   CNT_ONE    = {{RRF_SEL{1'b0}}, 1'b1};
  localparam logic [RRF_SEL-1:0] PTR_ONE    = {{(RRF_SEL-1){1'b0}}, 1'b1};

  logic [RRF_SEL-1:0] head_q, head_d;
  logic [RRF_SEL-1:0] tail_q, tail_d;
  logic [RRF_SEL:0]   count_q, count_d;
  logic [RRF_NUM-1:0] finished_q, finished_d;
  logic [RRF_NUM-1:0] dst_en_q;
  logic [REG_SEL-1:0] dst_num_q [RRF_NUM];

  logic alloc_s;
  logic commit_s;
  logic live_s;

  assign live_s   = (count_q != {(RRF_SEL+1){1'b0}});
  assign commit_s = live_s & finished_q[head_q];
  // The stall looks only at registered occupancy, so a same-cycle commit never frees a slot early.
  assign alloc_s  = dp_en_i & (count_q != FULL_COUNT);

  assign dp_stall_o             = (count_q == FULL_COUNT);
  assign dp_rrftag_o            = tail_q;
  assign free_num_o             = FULL_COUNT - count_q;
  assign commit_valid_o         = commit_s;
  assign completed_we_o         = commit_s & dst_en_q[head_q];
  assign completed_dst_num_o    = live_s ? dst_num_q[head_q] : {REG_SEL{1'b0}};
  assign completed_dst_rrftag_o = head_q;

  // Next-state for pointers, occupancy and completion flags.
  always_comb begin
    finished_d = finished_q;
    head_d     = commit_s ? (head_q + PTR_ONE) : head_q;
    tail_d     = alloc_s ? (tail_q + PTR_ONE) : tail_q;
    count_d    = count_q;
    finished_d[fin1_rrftag_i] = finished_d[fin1_rrftag_i] | fin1_en_i;
    finished_d[fin2_rrftag_i] = finished_d[fin2_rrftag_i] | fin2_en_i;
    finished_d[head_q]        = finished_d[head_q] & ~commit_s;
    // Applied last so a finish aimed at the tag being allocated is overridden.
    finished_d[tail_q]        = finished_d[tail_q] & ~alloc_s;
    case ({alloc_s, commit_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state register with reset and flush sharing one path.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      finished_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      finished_q <= finished_d;
    end
  end

  // Entry payload; only meaningful once the entry is counted live.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      dst_en_q[tail_q]  <= dp_dst_en_i;
      dst_num_q[tail_q] <= dp_dst_num_i;
    end
  end

endmodule
